prod_cons_ctrl: RTL and testbench

Sequencing controller for the producer/buffer/consumer datapath under `top`. It runs the six-state communication machine, gates the Fibonacci and Timer producers, and generates buffer writes from whichever producer is active. It paces buffer reads on the slow-clock tick and latches the consumed word for the display path. Its one-hot state vector drives `led`.

---
 rtl/prod_cons_ctrl.sv | 125 ++++++++++++
 tb/tb_prod_cons_ctrl.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/prod_cons_ctrl.sv
// Producer/buffer/consumer sequencing controller: gates the Fibonacci and Timer
// producers, steers buffer writes, and paces reads into the display latch.
//
// state     | meaning
// ----------+----------------------------------------------------------
// IDLE      | nothing running, reads suppressed
// COMM_F    | Fibonacci producer feeds the buffer
// WAIT_F    | Fibonacci paused on buffer full
// COMM_T    | Timer producer feeds the buffer
// WAIT_T    | Timer paused on buffer full
// BUF_EMPTY | production stopped, draining until buffer empty or resume
module prod_cons_ctrl #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_f,
  input  logic          start_t,
  input  logic          stop_f_t,
  input  logic          cons_tick,
  input  logic          fib_valid,
  input  logic [DW-1:0] fib_data,
  input  logic          tmr_valid,
  input  logic [DW-1:0] tmr_data,
  input  logic          buf_full,
  input  logic          buf_empty,
  input  logic [DW:0]   buf_rdata,
  output logic          fib_en,
  output logic          tmr_en,
  output logic          buf_wr,
  output logic [DW:0]   buf_wdata,
  output logic          buf_rd,
  output logic [DW-1:0] disp_data,
  output logic          disp_src,
  output logic          disp_valid,
  output logic [5:0]    led
);

  typedef enum logic [2:0] {
    IDLE      = 3'd0,
    COMM_F    = 3'd1,
    WAIT_F    = 3'd2,
    COMM_T    = 3'd3,
    WAIT_T    = 3'd4,
    BUF_EMPTY = 3'd5
  } state_t;

  state_t state;

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      buf_rd     <= 1'b0;
      disp_valid <= 1'b0;
      disp_data  <= '0;
      disp_src   <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_f)      state <= COMM_F;
          else if (start_t) state <= COMM_T;
        end
        COMM_F: begin
          if (stop_f_t)      state <= BUF_EMPTY;
          else if (buf_full) state <= WAIT_F;
        end
        WAIT_F: begin
          if (stop_f_t)       state <= BUF_EMPTY;
          else if (!buf_full) state <= COMM_F;
        end
        COMM_T: begin
          if (stop_f_t)      state <= BUF_EMPTY;
          else if (buf_full) state <= WAIT_T;
        end
        WAIT_T: begin
          if (stop_f_t)       state <= BUF_EMPTY;
          else if (!buf_full) state <= COMM_T;
        end
        BUF_EMPTY: begin
          // Resume keeps whatever is still queued in the buffer.
          if (start_f)        state <= COMM_F;
          else if (start_t)   state <= COMM_T;
          else if (buf_empty) state <= IDLE;
        end
        default: state <= IDLE;
      endcase

      // A tick that lands on an empty buffer is simply dropped.
      buf_rd     <= cons_tick && (state != IDLE) && !buf_empty;
      disp_valid <= buf_rd;
      if (buf_rd) begin
        disp_data <= buf_rdata[DW-1:0];
        disp_src  <= buf_rdata[DW];
      end
    end
  end

  always_comb begin
    fib_en    = (state == COMM_F) && !buf_full;
    tmr_en    = (state == COMM_T) && !buf_full;
    buf_wr    = 1'b0;
    buf_wdata = '0;
    if (state == COMM_F) begin
      buf_wr    = fib_valid && !buf_full;
      buf_wdata = {1'b0, fib_data};
    end else if (state == COMM_T) begin
      buf_wr    = tmr_valid && !buf_full;
      buf_wdata = {1'b1, tmr_data};
    end
  end

  always_comb begin
    led = 6'b000000;
    case (state)
      IDLE:      led = 6'b000001;
      COMM_F:    led = 6'b000010;
      WAIT_F:    led = 6'b000100;
      COMM_T:    led = 6'b001000;
      WAIT_T:    led = 6'b010000;
      BUF_EMPTY: led = 6'b100000;
      default:   led = 6'b000000;
    endcase
  end

endmodule

// File: tb/tb_prod_cons_ctrl.sv
// Self-checking bench for prod_cons_ctrl: write and read paths tracked by
// expected-value queues, state checked through led.
module tb_prod_cons_ctrl;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, start_f, start_t, stop_f_t, cons_tick;
  logic          fib_valid, tmr_valid, buf_full, buf_empty;
  logic [DW-1:0] fib_data, tmr_data;
  logic [DW:0]   buf_rdata;
  logic          fib_en, tmr_en, buf_wr, buf_rd, disp_src, disp_valid;
  logic [DW:0]   buf_wdata;
  logic [DW-1:0] disp_data;
  logic [5:0]    led;

  int assertions = 0;
  int failures   = 0;
  logic [DW:0] wr_q[$];
  logic [DW:0] rd_q[$];
  logic [DW:0] exp_w;

  prod_cons_ctrl #(.DW(DW)) dut (
    .clk(clk), .rst(rst), .start_f(start_f), .start_t(start_t),
    .stop_f_t(stop_f_t), .cons_tick(cons_tick), .fib_valid(fib_valid),
    .fib_data(fib_data), .tmr_valid(tmr_valid), .tmr_data(tmr_data),
    .buf_full(buf_full), .buf_empty(buf_empty), .buf_rdata(buf_rdata),
    .fib_en(fib_en), .tmr_en(tmr_en), .buf_wr(buf_wr), .buf_wdata(buf_wdata),
    .buf_rd(buf_rd), .disp_data(disp_data), .disp_src(disp_src),
    .disp_valid(disp_valid), .led(led)
  );

  always #5 clk = ~clk;

  // Inputs change 1 ns after the rising edge; checks happen 1 ns later still.
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1; start_f = 0; start_t = 0; stop_f_t = 0; cons_tick = 0;
    fib_valid = 0; tmr_valid = 0; buf_full = 0; buf_empty = 1;
    fib_data = '0; tmr_data = '0; buf_rdata = '0;
    cyc(); cyc();
    rst = 0;
    #1;
    assertions++; if (led !== 6'b000001) begin failures++; $display("FAIL reset_led got %b exp 000001", led); end
    assertions++; if ({fib_en, tmr_en, buf_wr, buf_rd, disp_valid} !== 5'b0) begin failures++; $display("FAIL reset_strobes got %b exp 00000", {fib_en, tmr_en, buf_wr, buf_rd, disp_valid}); end
    assertions++; if ({disp_src, disp_data} !== 17'h0) begin failures++; $display("FAIL reset_disp got %h exp 00000", {disp_src, disp_data}); end
  endtask

  task automatic test_fib_write();
    logic [DW-1:0] fib_seq [4];
    fib_seq[0] = 16'd1; fib_seq[1] = 16'd1; fib_seq[2] = 16'd2; fib_seq[3] = 16'd3;
    start_f = 1; cyc(); start_f = 0;
    assertions++; if (led !== 6'b000010) begin failures++; $display("FAIL fib_start_led got %b exp 000010", led); end
    for (int i = 0; i < 4; i++) begin
      fib_valid = 1; fib_data = fib_seq[i];
      wr_q.push_back({1'b0, fib_seq[i]});
      #1;
      exp_w = wr_q.pop_front();
      assertions++; if (buf_wr !== 1'b1 || fib_en !== 1'b1) begin failures++; $display("FAIL fib_wr%0d got wr=%b en=%b exp 1 1", i, buf_wr, fib_en); end
      assertions++; if (buf_wdata !== exp_w) begin failures++; $display("FAIL fib_wdata%0d got %h exp %h", i, buf_wdata, exp_w); end
      cyc();
    end
  endtask

  task automatic test_full_stall();
    fib_valid = 1; fib_data = 16'h0005; buf_full = 1;
    #1;
    assertions++; if (buf_wr !== 1'b0 || fib_en !== 1'b0) begin failures++; $display("FAIL full_gate got wr=%b en=%b exp 0 0", buf_wr, fib_en); end
    cyc();
    assertions++; if (led !== 6'b000100) begin failures++; $display("FAIL full_wait_led got %b exp 000100", led); end
    assertions++; if (buf_wr !== 1'b0) begin failures++; $display("FAIL wait_no_wr got %b exp 0", buf_wr); end
    buf_full = 0; cyc();
    assertions++; if (led !== 6'b000010) begin failures++; $display("FAIL full_resume_led got %b exp 000010", led); end
    fib_valid = 0;
    stop_f_t = 1; cyc(); stop_f_t = 0;
    assertions++; if (led !== 6'b100000) begin failures++; $display("FAIL fib_stop_led got %b exp 100000", led); end
    cyc();
    assertions++; if (led !== 6'b000001) begin failures++; $display("FAIL fib_drained_led got %b exp 000001", led); end
  endtask

  task automatic test_both_starts();
    start_f = 1; start_t = 1; cyc(); start_f = 0; start_t = 0;
    assertions++; if (led !== 6'b000010) begin failures++; $display("FAIL both_start_led got %b exp 000010", led); end
    start_t = 1; cyc(); start_t = 0;
    assertions++; if (led !== 6'b000010 || tmr_en !== 1'b0) begin failures++; $display("FAIL ignore_start_t got led=%b tmr_en=%b exp 000010 0", led, tmr_en); end
    stop_f_t = 1; cyc(); stop_f_t = 0; cyc();
    assertions++; if (led !== 6'b000001) begin failures++; $display("FAIL both_back_idle got %b exp 000001", led); end
  endtask

  task automatic test_timer_drain();
    logic [DW:0] rd_vals [3];
    rd_vals[0] = 17'h10007; rd_vals[1] = 17'h10007; rd_vals[2] = 17'h0BEEF;
    start_t = 1; cyc(); start_t = 0;
    assertions++; if (led !== 6'b001000) begin failures++; $display("FAIL tmr_start_led got %b exp 001000", led); end
    tmr_valid = 1; tmr_data = 16'h0042;
    wr_q.push_back({1'b1, 16'h0042});
    #1;
    exp_w = wr_q.pop_front();
    assertions++; if (buf_wr !== 1'b1 || tmr_en !== 1'b1 || fib_en !== 1'b0) begin failures++; $display("FAIL tmr_wr got wr=%b tmr_en=%b fib_en=%b exp 1 1 0", buf_wr, tmr_en, fib_en); end
    assertions++; if (buf_wdata !== exp_w) begin failures++; $display("FAIL tmr_wdata got %h exp %h", buf_wdata, exp_w); end
    tmr_valid = 0; buf_empty = 0; stop_f_t = 1; cyc(); stop_f_t = 0;
    assertions++; if (led !== 6'b100000) begin failures++; $display("FAIL tmr_stop_led got %b exp 100000", led); end
    for (int i = 0; i < 3; i++) begin
      cons_tick = 1; rd_q.push_back(rd_vals[i]);
      cyc(); cons_tick = 0; buf_rdata = rd_vals[i];
      #1;
      assertions++; if (buf_rd !== 1'b1 || disp_valid !== 1'b0) begin failures++; $display("FAIL tick%0d_rd got rd=%b dv=%b exp 1 0", i, buf_rd, disp_valid); end
      cyc(); buf_rdata = 17'h1FFFF;
      exp_w = rd_q.pop_front();
      assertions++; if (disp_valid !== 1'b1 || buf_rd !== 1'b0) begin failures++; $display("FAIL tick%0d_dv got dv=%b rd=%b exp 1 0", i, disp_valid, buf_rd); end
      assertions++; if ({disp_src, disp_data} !== exp_w) begin failures++; $display("FAIL tick%0d_disp got %h exp %h", i, {disp_src, disp_data}, exp_w); end
      cyc();
      assertions++; if (disp_valid !== 1'b0 || {disp_src, disp_data} !== exp_w) begin failures++; $display("FAIL tick%0d_hold got dv=%b disp=%h exp 0 %h", i, disp_valid, {disp_src, disp_data}, exp_w); end
    end
    buf_empty = 1; cyc();
    assertions++; if (led !== 6'b000001) begin failures++; $display("FAIL drain_idle_led got %b exp 000001", led); end
  endtask

  task automatic test_resume_and_idle_tick();
    start_f = 1; cyc(); start_f = 0;
    buf_empty = 0; stop_f_t = 1; cyc(); stop_f_t = 0;
    assertions++; if (led !== 6'b100000) begin failures++; $display("FAIL resume_pre_led got %b exp 100000", led); end
    start_f = 1; cyc(); start_f = 0;
    assertions++; if (led !== 6'b000010) begin failures++; $display("FAIL resume_led got %b exp 000010", led); end
    stop_f_t = 1; cyc(); stop_f_t = 0; buf_empty = 1; cyc();
    assertions++; if (led !== 6'b000001) begin failures++; $display("FAIL resume_idle_led got %b exp 000001", led); end
    buf_empty = 0; cons_tick = 1; cyc(); cons_tick = 0;
    assertions++; if (buf_rd !== 1'b0) begin failures++; $display("FAIL idle_tick_rd got %b exp 0", buf_rd); end
    cyc();
    assertions++; if (disp_valid !== 1'b0) begin failures++; $display("FAIL idle_tick_dv got %b exp 0", disp_valid); end
    buf_empty = 1;
  endtask

  task automatic test_reset_mid();
    start_t = 1; cyc(); start_t = 0; buf_full = 1; cyc();
    assertions++; if (led !== 6'b010000 || tmr_en !== 1'b0) begin failures++; $display("FAIL wait_t_led got led=%b tmr_en=%b exp 010000 0", led, tmr_en); end
    buf_empty = 0; cons_tick = 1; rst = 1; cyc(); cons_tick = 0; rst = 0;
    assertions++; if (led !== 6'b000001 || buf_rd !== 1'b0) begin failures++; $display("FAIL rst_mid_a got led=%b rd=%b exp 000001 0", led, buf_rd); end
    assertions++; if ({disp_src, disp_data} !== 17'h0) begin failures++; $display("FAIL rst_mid_disp got %h exp 00000", {disp_src, disp_data}); end
    cyc();
    assertions++; if (disp_valid !== 1'b0 || buf_rd !== 1'b0) begin failures++; $display("FAIL rst_mid_a_dv got dv=%b rd=%b exp 0 0", disp_valid, buf_rd); end
    start_t = 1; cyc(); start_t = 0; cyc();
    cons_tick = 1; buf_rdata = 17'h1AAAA; cyc(); cons_tick = 0; rst = 1;
    cyc(); rst = 0;
    assertions++; if (led !== 6'b000001 || disp_valid !== 1'b0) begin failures++; $display("FAIL rst_mid_b got led=%b dv=%b exp 000001 0", led, disp_valid); end
    cyc();
    assertions++; if (disp_valid !== 1'b0 || {disp_src, disp_data} !== 17'h0) begin failures++; $display("FAIL rst_mid_b_disp got dv=%b disp=%h exp 0 00000", disp_valid, {disp_src, disp_data}); end
    buf_full = 0; buf_empty = 1;
  endtask

  initial begin
    test_reset();
    test_fib_write();
    test_full_stall();
    test_both_starts();
    test_timer_drain();
    test_resume_and_idle_tick();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
